// File: rtl/wd_kick_gen.sv
// wd_kick_gen: sequences watchdog start/reset pulses for a job.
// The watchdog is armed when the job starts and re-armed (reset, then start) on
// forward progress, at most once per 2^KICK_BITS cycles. It is disarmed (reset
// only) when the job completes. Every pulse waits until its sync_pulse channel
// is idle and GAP cycles have passed since the previous pulse, so no pulse is
// swallowed by the clock-domain crossing.

module wd_kick_gen #(
  parameter int KICK_BITS = 16,
  parameter int GAP       = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        job_start,
  input  logic        job_active,
  input  logic        job_done,
  input  logic        start_busy,
  input  logic        reset_busy,
  output logic        wd_start,
  output logic        wd_reset,
  output logic        armed,
  output logic [15:0] kick_count
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  // IDLE:     watchdog not armed, waiting for a job
  // ARM_WAIT: job started, waiting to issue the arming start pulse
  // RUN:      armed, measuring the interval since the last (re)start
  // KICK_RST: re-arm in progress, waiting to issue the reset pulse
  // KICK_STA: re-arm in progress, waiting to issue the start pulse
  // DIS_WAIT: job done, waiting to issue the disarming reset pulse
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM_WAIT = 3'd1,
    RUN      = 3'd2,
    KICK_RST = 3'd3,
    KICK_STA = 3'd4,
    DIS_WAIT = 3'd5
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [GAP_W-1:0]       gap_cnt;
  logic [KICK_BITS-1:0]   interval_cnt;
  logic                   kick_pend;
  logic                   done_pend;

  logic                   gap_ok;
  logic                   can_start;
  logic                   can_reset;
  logic                   interval_sat;
  logic                   kick_req;
  logic                   done_seen;

  logic                   issue_start;
  logic                   issue_reset;
  logic                   arm_clear;
  logic                   kick_done;
  logic                   kick_pend_next;
  logic                   done_pend_next;

  // A pulse may only be issued once the spacing counter has drained and the
  // target channel reports idle.
  assign gap_ok       = (gap_cnt == '0);
  assign can_start    = gap_ok && !start_busy;
  assign can_reset    = gap_ok && !reset_busy;
  assign interval_sat = &interval_cnt;
  assign kick_req     = job_active || kick_pend;
  assign done_seen    = done_pend || job_done;

  // Progress seen too early is remembered until the interval has elapsed; it
  // is forgotten whenever RUN is left, since leaving RUN already re-arms or disarms.
  assign kick_pend_next = (state == RUN) && (state_next == RUN) && kick_req;

  // A completion seen mid re-arm is held until the sequence finishes its current pulse.
  assign done_pend_next = ((state == KICK_RST) || (state == KICK_STA)) &&
                          (state_next == state) && done_seen;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (job_start) begin
          state_next = can_start ? RUN : ARM_WAIT;
        end
      end
      ARM_WAIT: begin
        if (can_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (job_done) begin
          state_next = DIS_WAIT;
        end else if (kick_req && interval_sat) begin
          state_next = KICK_RST;
        end
      end
      KICK_RST: begin
        if (can_reset) begin
          state_next = done_seen ? IDLE : KICK_STA;
        end
      end
      KICK_STA: begin
        if (can_start) begin
          state_next = done_seen ? DIS_WAIT : RUN;
        end
      end
      DIS_WAIT: begin
        if (can_reset) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pulse issue decisions and armed/kick bookkeeping for the current state
  always_comb begin
    issue_start = 1'b0;
    issue_reset = 1'b0;
    arm_clear   = 1'b0;
    kick_done   = 1'b0;
    case (state)
      IDLE: begin
        issue_start = job_start && can_start;
      end
      ARM_WAIT: begin
        issue_start = can_start;
      end
      KICK_RST: begin
        issue_reset = can_reset;
        arm_clear   = can_reset && done_seen;
      end
      KICK_STA: begin
        issue_start = can_start;
        kick_done   = can_start;
      end
      DIS_WAIT: begin
        issue_reset = can_reset;
        arm_clear   = can_reset;
      end
      default: begin
        issue_start = 1'b0;
      end
    endcase
  end

  // Registered pulses and the armed flag; start and reset are issued from
  // disjoint states so they can never coincide.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wd_start <= 1'b0;
      wd_reset <= 1'b0;
      armed    <= 1'b0;
    end else begin
      wd_start <= issue_start;
      wd_reset <= issue_reset;
      if (issue_start) begin
        armed <= 1'b1;
      end else if (arm_clear) begin
        armed <= 1'b0;
      end
    end
  end

  // Spacing counter: reloads on every pulse and drains one per cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (issue_start || issue_reset) begin
      gap_cnt <= GAP_LOAD;
    end else if (!gap_ok) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Interval since the last start pulse, counted only while running
  always_ff @(posedge CLK) begin
    if (reset) begin
      interval_cnt <= '0;
    end else if (issue_start) begin
      interval_cnt <= '0;
    end else if ((state == RUN) && !interval_sat) begin
      interval_cnt <= interval_cnt + KICK_BITS'(1);
    end
  end

  // Pending progress and pending completion flags
  always_ff @(posedge CLK) begin
    if (reset) begin
      kick_pend <= 1'b0;
      done_pend <= 1'b0;
    end else begin
      kick_pend <= kick_pend_next;
      done_pend <= done_pend_next;
    end
  end

  // Completed re-arm sequences, saturating
  always_ff @(posedge CLK) begin
    if (reset) begin
      kick_count <= 16'd0;
    end else if (kick_done && (kick_count != 16'hFFFF)) begin
      kick_count <= kick_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wd_kick_gen.sv
// tb_wd_kick_gen: self-checking bench for wd_kick_gen.
// A hand-written vector table covers arming, disarming, pacing and reset
// corners; directed sequences cover busy stalls, completion during a re-arm
// and the re-arm rate limit; random traffic is compared against a model that
// tracks the job as a queue of pulses still owed to the watchdog.

module tb_wd_kick_gen;

  localparam int KICK_BITS = 4;
  localparam int GAP       = 4;

  localparam int P_START_ARM  = 1;
  localparam int P_RESET_KICK = 2;
  localparam int P_START_KICK = 3;
  localparam int P_RESET_OFF  = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        job_start;
  logic        job_active;
  logic        job_done;
  logic        start_busy;
  logic        reset_busy;
  logic        wd_start;
  logic        wd_reset;
  logic        armed;
  logic [15:0] kick_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: pulses still owed, in issue order
  int  plan[$];
  bit  m_armed     = 1'b0;
  bit  kick_wanted = 1'b0;
  int  cyc         = 0;
  int  last_pulse  = -1000;
  int  last_start  = -1000;
  int  m_count     = 0;
  bit  exp_start   = 1'b0;
  bit  exp_reset   = 1'b0;

  typedef struct {
    bit          rs;
    bit          js;
    bit          ja;
    bit          jd;
    bit          sb;
    bit          rb;
    bit          e_start;
    bit          e_reset;
    bit          e_armed;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[26];

  always #5 CLK = ~CLK;

  wd_kick_gen #(
    .KICK_BITS(KICK_BITS),
    .GAP(GAP)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .job_start(job_start),
    .job_active(job_active),
    .job_done(job_done),
    .start_busy(start_busy),
    .reset_busy(reset_busy),
    .wd_start(wd_start),
    .wd_reset(wd_reset),
    .armed(armed),
    .kick_count(kick_count)
  );

  function automatic vec_t mkVec(bit rs, bit js, bit ja, bit jd, bit sb, bit rb,
                                 bit es, bit er, bit ea, int ec);
    vec_t v;
    v.rs = rs; v.js = js; v.ja = ja; v.jd = jd; v.sb = sb; v.rb = rb;
    v.e_start = es; v.e_reset = er; v.e_armed = ea; v.e_count = 16'(ec);
    return v;
  endfunction

  // Reference model: one call per clock with that cycle's inputs; leaves the
  // expected post-edge outputs in exp_start/exp_reset/m_armed/m_count.
  task automatic modelStep(input bit rs, input bit js, input bit ja, input bit jd,
                           input bit sb, input bit rb);
    bit from_run;
    int head;
    from_run  = 1'b0;
    exp_start = 1'b0;
    exp_reset = 1'b0;
    if (rs) begin
      plan.delete();
      m_armed     = 1'b0;
      kick_wanted = 1'b0;
      m_count     = 0;
      last_pulse  = cyc - 1000;
    end else begin
      if (plan.size() == 0) begin
        if (!m_armed) begin
          if (js) plan.push_back(P_START_ARM);
        end else begin
          from_run = 1'b1;
          if (jd) begin
            plan.push_back(P_RESET_OFF);
            kick_wanted = 1'b0;
          end else if (ja || kick_wanted) begin
            if ((cyc - last_start) >= (1 << KICK_BITS)) begin
              plan.push_back(P_RESET_KICK);
              plan.push_back(P_START_KICK);
              kick_wanted = 1'b0;
            end else begin
              kick_wanted = 1'b1;
            end
          end
        end
      end else if (jd) begin
        if (plan[0] == P_RESET_KICK) begin
          plan.delete();
          plan.push_back(P_RESET_OFF);
        end else if (plan[0] == P_START_KICK && plan.size() == 1) begin
          plan.push_back(P_RESET_OFF);
        end
      end
      if (!from_run && plan.size() != 0 && (cyc - last_pulse) > GAP) begin
        head = plan[0];
        if ((head == P_START_ARM || head == P_START_KICK) && !sb) begin
          exp_start  = 1'b1;
          plan.delete(0);
          last_pulse = cyc;
          last_start = cyc;
          m_armed    = 1'b1;
          if (head == P_START_KICK && m_count < 65535) m_count++;
        end else if ((head == P_RESET_KICK || head == P_RESET_OFF) && !rb) begin
          exp_reset  = 1'b1;
          plan.delete(0);
          last_pulse = cyc;
          if (head == P_RESET_OFF) m_armed = 1'b0;
        end
      end
    end
    cyc++;
  endtask

  // Drive one cycle of inputs, advance the model, and sample just after the edge
  task automatic applyStimulus(input bit rs, input bit js, input bit ja, input bit jd,
                               input bit sb, input bit rb);
    reset      = rs;
    job_start  = js;
    job_active = ja;
    job_done   = jd;
    start_busy = sb;
    reset_busy = rb;
    modelStep(rs, js, ja, jd, sb, rb);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkValue(input string name, input longint got, input longint want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input bit es, input bit er,
                             input bit ea, input int ec);
    checkValue({name, ".wd_start"}, longint'(wd_start), longint'(es));
    checkValue({name, ".wd_reset"}, longint'(wd_reset), longint'(er));
    checkValue({name, ".armed"}, longint'(armed), longint'(ea));
    checkValue({name, ".kick_count"}, longint'(kick_count), longint'(ec));
  endtask

  initial begin
    int n_rst;
    int n_sta;
    int last_rst_i;
    int min_rs;
    int min_rr;

    reset = 1'b0; job_start = 1'b0; job_active = 1'b0;
    job_done = 1'b0; start_busy = 1'b0; reset_busy = 1'b0;

    //                 rs js ja jd sb rb   st rs ar cnt
    vecs[0]  = mkVec(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[2]  = mkVec(0, 1, 0, 0, 0, 0,   1, 0, 1, 0);
    vecs[3]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    vecs[4]  = mkVec(0, 0, 1, 1, 0, 0,   0, 0, 1, 0);
    vecs[5]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    vecs[6]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    vecs[7]  = mkVec(0, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    vecs[8]  = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[9]  = mkVec(0, 1, 0, 0, 1, 0,   0, 0, 0, 0);
    vecs[10] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[11] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[12] = mkVec(0, 0, 0, 0, 0, 0,   1, 0, 1, 0);
    vecs[13] = mkVec(0, 1, 0, 0, 0, 0,   0, 0, 1, 0);
    vecs[14] = mkVec(1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[15] = mkVec(0, 1, 0, 1, 0, 0,   1, 0, 1, 0);
    vecs[16] = mkVec(0, 0, 0, 1, 0, 0,   0, 0, 1, 0);
    vecs[17] = mkVec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    vecs[18] = mkVec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    vecs[19] = mkVec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    vecs[20] = mkVec(0, 0, 0, 0, 0, 1,   0, 0, 1, 0);
    vecs[21] = mkVec(1, 0, 0, 0, 0, 1,   0, 0, 0, 0);
    vecs[22] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[23] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[24] = mkVec(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    vecs[25] = mkVec(0, 0, 1, 1, 0, 0,   0, 0, 0, 0);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].rs, vecs[i].js, vecs[i].ja, vecs[i].jd, vecs[i].sb, vecs[i].rb);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_reset,
                  vecs[i].e_armed, int'(vecs[i].e_count));
    end

    // Start channel busy for 20 cycles after job_start: no pulse until it clears
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("busy_reset", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkOutput("busy_jobstart", 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput($sformatf("busy_hold%0d", i), 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("busy_release", 1, 0, 1, 0);

    // Completion while the re-arm reset is stalled: one reset, no restart
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, 0, 0, 1);
      checkOutput($sformatf("kickrst_run%0d", i), 0, 0, 1, 0);
    end
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("kickrst_done", 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("kickrst_reset_issued", 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("kickrst_quiet%0d", i), 0, 0, 0, 0);
    end

    // Back in IDLE: a fresh job arms immediately
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("rate_arm", 1, 0, 1, 0);

    // Continuous progress for four full intervals plus pulse overhead
    n_rst = 0; n_sta = 0; last_rst_i = -1000; min_rs = 1000; min_rr = 1000;
    for (int i = 0; i < 118; i++) begin
      applyStimulus(0, 0, (i < 88), 0, 0, 0);
      if (wd_reset === 1'b1) begin
        n_rst++;
        if (i - last_rst_i < min_rr) min_rr = i - last_rst_i;
        last_rst_i = i;
      end
      if (wd_start === 1'b1) begin
        n_sta++;
        if (i - last_rst_i < min_rs) min_rs = i - last_rst_i;
      end
    end
    checkValue("rate_reset_pulses", n_rst, 4);
    checkValue("rate_start_pulses", n_sta, 4);
    checkValue("rate_reset_to_start_ge_gap", (min_rs >= GAP) ? 1 : 0, 1);
    checkValue("rate_reset_to_reset_ge_interval", (min_rr >= (1 << KICK_BITS)) ? 1 : 0, 1);
    checkValue("rate_kick_count", longint'(kick_count), 4);
    checkValue("rate_still_armed", longint'(armed), 1);

    // Random traffic against the model
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("rand_reset", exp_start, exp_reset, m_armed, m_count);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
      checkOutput($sformatf("rand%0d", i), exp_start, exp_reset, m_armed, m_count);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
